// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front-end and result-drain blocks:
// job sequencing states and the packed-lane slicing helper.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // LSB position of lane 'lane' inside a packed vector of 'width'-bit elements
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// DEPTH-stage shift register with asynchronous clear; the last stage doubles as
// the lane's output register.
module skew_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stage [DEPTH];

  // Shift chain: stage 0 captures the input, later stages follow one cycle apart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
    end else begin
      stage[0] <= din;
      for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Front-end of the NxN PE array: sequences a job (clear, stream, flush, done)
// and skews the A-column / B-row beats onto the array's left and top edges.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int N          = 4,
  parameter  int K_MAX      = 255,
  localparam int KW         = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  output logic [N*DATA_WIDTH-1:0] left_out,
  output logic [N*DATA_WIDTH-1:0] up_out,
  output logic                    arr_clr,
  output logic                    busy,
  output logic                    done
);

  localparam int FW = $clog2(2 * N);

  state_t                  state;
  logic [KW-1:0]           k_len_r;
  logic [KW-1:0]           beat_cnt;
  logic [FW-1:0]           flush_cnt;
  logic                    accept;
  logic [N*DATA_WIDTH-1:0] feed_a;
  logic [N*DATA_WIDTH-1:0] feed_b;

  assign in_ready = (state == ST_LOAD);
  assign accept   = in_valid & in_ready;
  // Cycles without an accepted beat push zeros so A and B stay pair-aligned
  assign feed_a   = accept ? in_a : '0;
  assign feed_b   = accept ? in_b : '0;

  // Job sequencer with registered arr_clr / busy / done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k_len_r   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      arr_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      arr_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && (k_len != '0)) begin
            state    <= ST_LOAD;
            k_len_r  <= k_len;
            beat_cnt <= '0;
            arr_clr  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == (k_len_r - KW'(1))) begin
              state     <= ST_FLUSH;
              flush_cnt <= FW'(2 * N - 2);
            end
          end
        end
        ST_FLUSH: begin
          // 2N-1 zero cycles let the last beat reach PE(N-1,N-1)
          if (flush_cnt == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_a (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (feed_a[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .dout (left_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );
    skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(i + 1)) u_b (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (feed_b[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .dout (up_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: job-level reference model (accepted-beat log,
// expected timeline) plus a behavioural PE-array sum built from the edge outputs.
module tb_systolic_feeder;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int KW   = 8;
  localparam int MAXC = 4096;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_a;
  logic [N*DW-1:0] in_b;
  logic [N*DW-1:0] left_out;
  logic [N*DW-1:0] up_out;
  logic            arr_clr;
  logic            busy;
  logic            done;

  systolic_feeder #(.DATA_WIDTH(DW), .N(N), .K_MAX(255)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .k_len   (k_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a    (in_a),
    .in_b    (in_b),
    .left_out(left_out),
    .up_out  (up_out),
    .arr_clr (arr_clr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // reference model: job timeline and log of accepted beats per cycle window
  bit              m_load;
  int              m_left;
  int              m_nacc;
  int              m_done_cyc;
  int              m_clr_cyc;
  int              floor_cyc;
  logic [N*DW-1:0] acc_a  [MAXC];
  logic [N*DW-1:0] acc_b  [MAXC];
  logic [N*DW-1:0] hist_l [MAXC];
  logic [N*DW-1:0] hist_u [MAXC];
  int unsigned     got_sum [N][N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_load     = 1'b0;
    m_left     = 0;
    m_nacc     = 0;
    m_done_cyc = -100;
    m_clr_cyc  = -100;
    floor_cyc  = cyc;
  endtask

  function automatic logic [N*DW-1:0] exp_edge(input bit is_b);
    logic [N*DW-1:0] v;
    logic [N*DW-1:0] src;
    int idx;
    v = '0;
    for (int i = 0; i < N; i++) begin
      idx = cyc - 1 - i;
      if (idx >= floor_cyc) begin
        src = is_b ? acc_b[idx] : acc_a[idx];
        v[i*DW +: DW] = src[i*DW +: DW];
      end
    end
    return v;
  endfunction

  // advance one clock, update the model with what the edge consumed, check outputs
  task automatic tick();
    bit prev_idle;
    bit was_load;
    @(posedge clk);
    #1;
    cyc++;
    prev_idle = !m_load && (cyc - 1 > m_done_cyc);
    was_load  = m_load;
    acc_a[cyc-1] = '0;
    acc_b[cyc-1] = '0;
    if (was_load && in_valid) begin
      acc_a[cyc-1] = in_a;
      acc_b[cyc-1] = in_b;
      m_nacc++;
      m_left--;
      if (m_left == 0) begin
        m_load     = 1'b0;
        m_done_cyc = cyc + 2 * N - 1;
      end
    end
    if (prev_idle && start && (k_len != '0)) begin
      m_load    = 1'b1;
      m_left    = int'(k_len);
      m_nacc    = 0;
      m_clr_cyc = cyc;
    end
    hist_l[cyc] = left_out;
    hist_u[cyc] = up_out;
    check("in_ready", in_ready, m_load);
    check("busy", busy, m_load || (cyc <= m_done_cyc));
    check("done", done, cyc == m_done_cyc);
    check("arr_clr", arr_clr, cyc == m_clr_cyc);
    check("left_out", left_out, exp_edge(1'b0));
    check("up_out", up_out, exp_edge(1'b1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_left"}, left_out, '0);
    check({tag, "_up"}, up_out, '0);
    check({tag, "_ready"}, in_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_clr"}, arr_clr, 1'b0);
  endtask

  // assert rst_n mid-cycle, verify the async clear, hold two edges, release
  task automatic do_reset();
    #2;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      cyc++;
      hist_l[cyc] = '0;
      hist_u[cyc] = '0;
    end
    check_all_zero("held_rst");
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic drive_beat(input int dmode);
    for (int i = 0; i < N; i++) begin
      case (dmode)
        0: begin
          in_a[i*DW +: DW] = DW'(i + 1);
          in_b[i*DW +: DW] = DW'(i + 1);
        end
        1: begin
          in_a[i*DW +: DW] = (i == m_nacc) ? 8'd1 : 8'd0;
          in_b[i*DW +: DW] = (i == m_nacc) ? 8'd1 : 8'd0;
        end
        default: begin
          in_a[i*DW +: DW] = DW'($urandom_range(0, 255));
          in_b[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
      endcase
    end
  endtask

  // vmode: 0 always valid, 1 toggle 1/0, 2 random; dmode: 0 ramp, 1 identity, 2 random
  task automatic run_job(input int klen, input int vmode, input int dmode,
                         input bit noise, input bit abort);
    int guard;
    int ph;
    int unsigned exp_s;
    start = 1'b1;
    k_len = KW'(klen);
    tick();
    start = 1'b0;
    k_len = '0;
    guard = 0;
    ph    = 0;
    while (m_load && guard < 200) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (ph % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      ph++;
      drive_beat(dmode);
      if (noise) begin
        start = 1'b1;
        k_len = KW'($urandom_range(1, 8));
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    k_len    = '0;
    in_a     = '0;
    in_b     = '0;
    if (m_load) check("load_timeout", 1'b1, 1'b0);
    guard = 0;
    while (cyc < m_done_cyc && guard < 100) begin
      if (abort && cyc == m_done_cyc - 3) begin
        do_reset();
        return;
      end
      tick();
      guard++;
    end
    if (cyc != m_done_cyc) begin
      check("done_timeout", 1'b1, 1'b0);
      return;
    end
    // PE(i,j) sees left lane i delayed j cycles and top lane j delayed i cycles
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        got_sum[i][j] = 0;
        exp_s = 0;
        for (int w = m_clr_cyc + 1; w <= m_done_cyc; w++)
          got_sum[i][j] += hist_l[w-j][i*DW +: DW] * hist_u[w-i][j*DW +: DW];
        for (int w = m_clr_cyc; w < m_done_cyc; w++)
          exp_s += acc_a[w][i*DW +: DW] * acc_b[w][j*DW +: DW];
        check("pe_sum", got_sum[i][j], exp_s);
      end
    end
    tick();
  endtask

  task automatic check_sums_identity(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check(tag, got_sum[i][j], (i == j) ? 64'd1 : 64'd0);
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    model_clear();

    // power-on reset values
    #3;
    check_all_zero("por");
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      cyc++;
      hist_l[cyc] = '0;
      hist_u[cyc] = '0;
    end
    rst_n = 1'b1;
    model_clear();
    repeat (4) tick();

    // start with k_len == 0 is ignored
    start = 1'b1;
    k_len = '0;
    repeat (3) tick();
    start = 1'b0;
    repeat (2) tick();

    // single ramp beat: PE(i,j) = (i+1)*(j+1)
    run_job(1, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check("ramp_sum", got_sum[i][j], (i + 1) * (j + 1));
    repeat (2) tick();

    // identity, back-to-back beats
    run_job(4, 0, 1, 1'b0, 1'b0);
    check_sums_identity("ident_b2b");
    repeat (2) tick();

    // identity with alternating valid: bubbles must not disturb the product
    run_job(4, 1, 1, 1'b0, 1'b0);
    check_sums_identity("ident_bubble");
    repeat (2) tick();

    // start pulses while LOAD is active are ignored
    run_job(4, 0, 2, 1'b1, 1'b0);
    repeat (2) tick();

    // reset during FLUSH aborts the job, then a fresh job completes
    run_job(3, 2, 2, 1'b0, 1'b1);
    repeat (3) tick();
    run_job(2, 0, 1, 1'b0, 1'b0);
    repeat (2) tick();

    // randomized jobs
    for (int n = 0; n < 12; n++) begin
      run_job($urandom_range(1, 8), 2, 2, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
